// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480 VGA sync/blanking generator with pixel clock divider and frame counter
module vga_timing_gen #(
  parameter int DIV     = 4,
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic       pix_tick,
  output logic       frame_tick,
  output logic [7:0] frame_count
);
  logic [3:0] div_q, div_n;
  logic [9:0] h_n, v_n;
  logic h_end, v_end, wrap;
  assign pix_tick = div_q == 4'(DIV - 1);
  // next-state counters; syncs and blanking decode from these so they switch with the counters
  always_comb begin
    h_end = hCount == 10'(H_TOTAL - 1);
    v_end = vCount == 10'(V_TOTAL - 1);
    wrap  = pix_tick && h_end && v_end;
    div_n = pix_tick ? 4'd0 : div_q + 4'd1;
    h_n   = !pix_tick ? hCount : h_end ? 10'd0 : hCount + 10'd1;
    v_n   = !(pix_tick && h_end) ? vCount : v_end ? 10'd0 : vCount + 10'd1;
  end
  // counters and registered timing outputs; reset is asynchronous and active-low
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      div_q       <= '0;
      hCount      <= '0;
      vCount      <= '0;
      hSync       <= 1'b0;
      vSync       <= 1'b0;
      bright      <= 1'b0;
      frame_tick  <= 1'b0;
      frame_count <= '0;
    end else begin
      div_q      <= div_n;
      hCount     <= h_n;
      vCount     <= v_n;
      hSync      <= h_n > 10'd95;
      vSync      <= v_n > 10'd1;
      bright     <= h_n >= 10'd144 && h_n <= 10'd783 && v_n >= 10'd35 && v_n <= 10'd514;
      frame_tick <= wrap;
      if (wrap) frame_count <= frame_count + 8'd1;
    end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter DIV, default 4: system clocks per pixel; legal range 2..16.
REQ-002 Parameter H_TOTAL, default 800: pixel counts per line.
REQ-003 Parameter V_TOTAL, default 525: lines per frame.
REQ-004 Port clk  in  1: single system clock (100 MHz); every register updates on its rising edge.
REQ-005 Port rst  in  1: reset, asynchronous assert, active-low (0 = reset).
REQ-006 Port hCount  out  10: horizontal pixel count, 0..H_TOTAL-1.
REQ-007 Port vCount  out  10: vertical line count, 0..V_TOTAL-1.
REQ-008 Port hSync  out  1: horizontal sync, active-low.
REQ-009 Port vSync  out  1: vertical sync, active-low.
REQ-010 Port bright  out  1: high only inside the 640x480 visible area.
REQ-011 Port pix_tick  out  1: one-clk pixel-enable strobe.
REQ-012 Port frame_tick  out  1: one-clk strobe at each frame start.
REQ-013 Port frame_count  out  8: frames completed since reset, modulo 256.

Function
REQ-014 Divider counter SHALL count 0..DIV-1 and wrap; pix_tick SHALL be 1 exactly in cycles where divider == DIV-1.
REQ-015 hCount SHALL advance only in pix_tick cycles: +1, wrapping H_TOTAL-1 -> 0.
REQ-016 vCount SHALL advance only in a pix_tick cycle where hCount == H_TOTAL-1: +1, wrapping V_TOTAL-1 -> 0; otherwise it holds.
REQ-017 Horizontal timing (pixels): sync 0..95, back porch 96..143, visible 144..783, front porch 784..799.
REQ-018 Vertical timing (lines): sync 0..1, back porch 2..34, visible 35..514, front porch 515..524.
REQ-019 hSync SHALL be 0 exactly when hCount <= 95; vSync SHALL be 0 exactly when vCount <= 1.
REQ-020 bright SHALL be 1 exactly when 144 <= hCount <= 783 and 35 <= vCount <= 514.
REQ-021 hSync, vSync and bright SHALL be registered, decoded from next-state counter values, so they change on the same edge as the counters with no combinational glitches.
REQ-022 frame_tick SHALL be 1 for exactly one clk, in the cycle after the edge where counters move from (799,524) to (0,0).
REQ-023 frame_count SHALL increment on that same edge, wrapping 255 -> 0.
REQ-024 Latency: counters SHALL leave (0,0) on the DIV-th rising edge after reset release; one frame = H_TOTAL*V_TOTAL*DIV clks (1,680,000 at defaults).
REQ-025 Counter widths SHALL not overflow: 10-bit comparisons, no sign extension, no intermediate value above 1023.

Reset
REQ-026 While rst == 0: divider = 0, hCount = 0, vCount = 0, hSync = 0, vSync = 0, bright = 0, pix_tick = 0, frame_tick = 0, frame_count = 0.
REQ-027 Reset asserted mid-frame SHALL force the REQ-026 values immediately, independent of clk.
REQ-028 After rst returns to 1, the first full frame SHALL start from (0,0) with no frame_tick for the truncated frame.

Verification
REQ-029 Release reset at t0 -> pix_tick first 1 on clk edge 4; hCount = 1 after edge 4; hSync stays 0 for 96 pixels (384 clks).
REQ-030 Run one line -> hSync rises when hCount goes 95 -> 96; vCount goes 0 -> 1 when hCount wraps 799 -> 0.
REQ-031 Scan a full frame -> bright first 1 at (144,35), last 1 at (783,514); total bright-high pixels = 307,200.
REQ-032 Run 2 frames -> frame_tick pulses exactly twice, 1,680,000 clks apart, each 1 clk wide; frame_count = 2.
REQ-033 Assert rst at (400,300) for 3 clks, then release -> all outputs equal REQ-026 values during reset; next frame_tick arrives 1,680,000 clks after release.
REQ-034 Run 256 frames (DIV = 2 for speed) -> frame_count wraps 255 -> 0 on the 256th frame_tick.
